// File: rtl/mmio_slot_router_if.sv
// CPU-side WISHBONE bus between the processor and the MMIO slot router.
// AW = SLOT_AW + REG_AW. The router uses the slave modport and the CPU uses the master modport.
interface mmio_slot_router_if #(
  parameter int AW = 11,
  parameter int DW = 32
);
  logic [AW-1:0] ADDR_I;
  logic [DW-1:0] DAT_I;
  logic [DW-1:0] DAT_O;
  logic          CYC_I;
  logic          STB_I;
  logic          WE_I;
  logic          ACK_O;
  logic          ERR_O;

  modport master (
    output ADDR_I, DAT_I, CYC_I, STB_I, WE_I,
    input  DAT_O, ACK_O, ERR_O
  );

  modport slave (
    input  ADDR_I, DAT_I, CYC_I, STB_I, WE_I,
    output DAT_O, ACK_O, ERR_O
  );
endinterface

// File: rtl/mmio_slot_router.sv
// Registered WISHBONE decoder that fans one CPU bus out to N_SLOTS I/O cores.
// Disabled or silent slots get a deterministic ACK/ERR, and the last failing access is latched.
module mmio_slot_router #(
  parameter int                 N_SLOTS    = 64,
  parameter int                 REG_AW     = 5,
  parameter int                 DW         = 32,
  parameter logic [N_SLOTS-1:0] SLOT_EN    = '1,
  parameter bit                 UNUSED_ERR = 1'b0,
  parameter int                 TIMEOUT    = 255,
  localparam int                SLOT_AW    = $clog2(N_SLOTS)
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  mmio_slot_router_if.slave     bus,
  output logic [N_SLOTS-1:0]    CYC_O,
  output logic [N_SLOTS-1:0]    STB_O,
  output logic                  WE_O,
  output logic [REG_AW-1:0]     ADDR_O,
  output logic [DW-1:0]         DAT_W_O,
  input  logic [N_SLOTS*DW-1:0] DAT_R_I,
  input  logic [N_SLOTS-1:0]    ACK_I,
  output logic                  err_valid,
  output logic [SLOT_AW-1:0]    err_slot,
  output logic                  err_timeout,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t               state;
  logic [SLOT_AW-1:0]   slot_q;
  logic [15:0]          count;
  logic [N_SLOTS-1:0]   sel_q;
  logic [DW-1:0]        dat_q;
  logic                 ack_q;
  logic                 err_q;

  logic [SLOT_AW-1:0]   req_slot;
  logic [REG_AW-1:0]    req_reg;
  logic [N_SLOTS-1:0]   req_onehot;
  logic [DW-1:0]        slot_rdata;

  assign req_slot   = bus.ADDR_I[SLOT_AW+REG_AW-1:REG_AW];
  assign req_reg    = bus.ADDR_I[REG_AW-1:0];
  assign req_onehot = {{(N_SLOTS-1){1'b0}}, 1'b1} << req_slot;
  assign slot_rdata = DAT_R_I[int'(slot_q)*DW +: DW];

  assign CYC_O      = sel_q;
  assign STB_O      = sel_q;
  assign bus.DAT_O  = dat_q;
  assign bus.ACK_O  = ack_q;
  assign bus.ERR_O  = err_q;

  // A new error in the same cycle as err_clr wins because its assignment comes later in the block.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state       <= IDLE;
      slot_q      <= '0;
      count       <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      WE_O        <= 1'b0;
      ADDR_O      <= '0;
      DAT_W_O     <= '0;
      err_valid   <= 1'b0;
      err_slot    <= '0;
      err_timeout <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (err_clr) begin
        err_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.CYC_I && bus.STB_I) begin
            slot_q  <= req_slot;
            ADDR_O  <= req_reg;
            WE_O    <= bus.WE_I;
            DAT_W_O <= bus.DAT_I;
            count   <= '0;
            if (SLOT_EN[req_slot]) begin
              state <= REQ;
              sel_q <= req_onehot;
            end else begin
              state <= RESP;
              dat_q <= '0;
              if (UNUSED_ERR) begin
                err_q       <= 1'b1;
                err_valid   <= 1'b1;
                err_slot    <= req_slot;
                err_timeout <= 1'b0;
              end else begin
                ack_q <= 1'b1;
              end
            end
          end
        end

        // An abort wins over a same-cycle slave ACK so a dropped cycle never terminates.
        REQ: begin
          if (!bus.CYC_I) begin
            state <= IDLE;
            sel_q <= '0;
            count <= '0;
          end else if (ACK_I[slot_q]) begin
            state <= RESP;
            sel_q <= '0;
            count <= '0;
            ack_q <= 1'b1;
            dat_q <= WE_O ? '0 : slot_rdata;
          end else if (count == 16'(TIMEOUT - 1)) begin
            state       <= RESP;
            sel_q       <= '0;
            count       <= '0;
            err_q       <= 1'b1;
            dat_q       <= '0;
            err_valid   <= 1'b1;
            err_slot    <= slot_q;
            err_timeout <= 1'b1;
          end else begin
            count <= count + 16'd1;
          end
        end

        RESP: begin
          state <= IDLE;
          count <= '0;
        end

        default: begin
          state <= IDLE;
          sel_q <= '0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_slot_router.sv
// Two routers (UNUSED_ERR=0 and 1) share the same stimulus, and each one is checked
// against the expected response derived from the access rules.
module tb_mmio_slot_router;

  localparam int             NS  = 8;
  localparam int             RAW = 5;
  localparam int             DW  = 32;
  localparam int             AW  = 3 + RAW;
  localparam int             TMO = 8;
  localparam logic [NS-1:0]  EN  = 8'h07;

  typedef struct {
    logic [2:0]  slot;
    logic [4:0]  rsel;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        clr;
    int          lat;
    int          stb_cycles;
    logic        err_a;
    logic        err_b;
    logic        tmo;
    logic [31:0] dat;
  } vec_t;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;
  always #5 CLK_I = ~CLK_I;

  logic             cyc = 1'b0, stb = 1'b0, we = 1'b0, err_clr = 1'b0;
  logic [AW-1:0]    addr = '0;
  logic [DW-1:0]    wdat = '0;
  logic [NS*DW-1:0] dat_r = '0;
  logic [NS-1:0]    ack_i = '0;

  logic [NS-1:0]  cyc_o [2];
  logic [NS-1:0]  stb_o [2];
  logic           we_o [2];
  logic [RAW-1:0] addr_o [2];
  logic [DW-1:0]  dat_w_o [2];
  logic           ev [2];
  logic [2:0]     es [2];
  logic           et [2];
  logic           ack_o [2];
  logic           err_o [2];
  logic [DW-1:0]  dat_o [2];

  int n_vec  = 0;
  int n_miss = 0;

  logic       mv [2];
  logic [2:0] ms [2];
  logic       mt [2];

  mmio_slot_router_if #(.AW(AW), .DW(DW)) bus_a ();
  mmio_slot_router_if #(.AW(AW), .DW(DW)) bus_b ();

  assign bus_a.CYC_I  = cyc;
  assign bus_a.STB_I  = stb;
  assign bus_a.WE_I   = we;
  assign bus_a.ADDR_I = addr;
  assign bus_a.DAT_I  = wdat;
  assign bus_b.CYC_I  = cyc;
  assign bus_b.STB_I  = stb;
  assign bus_b.WE_I   = we;
  assign bus_b.ADDR_I = addr;
  assign bus_b.DAT_I  = wdat;

  assign ack_o[0] = bus_a.ACK_O;
  assign err_o[0] = bus_a.ERR_O;
  assign dat_o[0] = bus_a.DAT_O;
  assign ack_o[1] = bus_b.ACK_O;
  assign err_o[1] = bus_b.ERR_O;
  assign dat_o[1] = bus_b.DAT_O;

  mmio_slot_router #(
    .N_SLOTS(NS), .REG_AW(RAW), .DW(DW), .SLOT_EN(EN), .UNUSED_ERR(1'b0), .TIMEOUT(TMO)
  ) dut_a (
    .CLK_I(CLK_I), .RST_I(RST_I), .bus(bus_a),
    .CYC_O(cyc_o[0]), .STB_O(stb_o[0]), .WE_O(we_o[0]), .ADDR_O(addr_o[0]),
    .DAT_W_O(dat_w_o[0]), .DAT_R_I(dat_r), .ACK_I(ack_i),
    .err_valid(ev[0]), .err_slot(es[0]), .err_timeout(et[0]), .err_clr(err_clr)
  );

  mmio_slot_router #(
    .N_SLOTS(NS), .REG_AW(RAW), .DW(DW), .SLOT_EN(EN), .UNUSED_ERR(1'b1), .TIMEOUT(TMO)
  ) dut_b (
    .CLK_I(CLK_I), .RST_I(RST_I), .bus(bus_b),
    .CYC_O(cyc_o[1]), .STB_O(stb_o[1]), .WE_O(we_o[1]), .ADDR_O(addr_o[1]),
    .DAT_W_O(dat_w_o[1]), .DAT_R_I(dat_r), .ACK_I(ack_i),
    .err_valid(ev[1]), .err_slot(es[1]), .err_timeout(et[1]), .err_clr(err_clr)
  );

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic check_output(input string name, input int d, input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s dut%0d: got %h, expected %h", name, d, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_output({tag, "_stb"}, d, 32'(stb_o[d]), 32'h0);
      check_output({tag, "_cyc"}, d, 32'(cyc_o[d]), 32'h0);
      check_output({tag, "_we"}, d, 32'(we_o[d]), 32'h0);
      check_output({tag, "_addr"}, d, 32'(addr_o[d]), 32'h0);
      check_output({tag, "_datw"}, d, dat_w_o[d], 32'h0);
      check_output({tag, "_ack"}, d, 32'(ack_o[d]), 32'h0);
      check_output({tag, "_err"}, d, 32'(err_o[d]), 32'h0);
      check_output({tag, "_dat"}, d, dat_o[d], 32'h0);
      check_output({tag, "_evalid"}, d, 32'(ev[d]), 32'h0);
      check_output({tag, "_eslot"}, d, 32'(es[d]), 32'h0);
      check_output({tag, "_etmo"}, d, 32'(et[d]), 32'h0);
    end
  endtask

  task automatic check_latch(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_output({tag, "_evalid"}, d, 32'(ev[d]), 32'(mv[d]));
      check_output({tag, "_eslot"}, d, 32'(es[d]), 32'(ms[d]));
      check_output({tag, "_etmo"}, d, 32'(et[d]), 32'(mt[d]));
    end
  endtask

  // Bench-side slave: acks its slot on the (waits+1)-th strobe cycle and sprays ACK_I noise on other slots.
  task automatic apply_stimulus(input vec_t v);
    logic [NS-1:0] hot;
    logic [NS-1:0] noise;
    logic          e;
    int            seen;
    hot = '0;
    hot[v.slot] = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = v.we; addr = {v.slot, v.rsel}; wdat = v.wdata;
    err_clr = v.clr; ack_i = '0;
    for (int s = 0; s < NS; s++) dat_r[s*DW +: DW] = (s == int'(v.slot)) ? v.rdata : $urandom;
    seen = 0;
    for (int n = 1; n <= v.lat + 1; n++) begin
      tick();
      err_clr = 1'b0;
      ack_i = '0;
      for (int d = 0; d < 2; d++) begin
        e = (d == 0) ? v.err_a : v.err_b;
        check_output("stb", d, 32'(stb_o[d]), (n <= v.stb_cycles) ? 32'(hot) : 32'h0);
        check_output("cyc", d, 32'(cyc_o[d]), (n <= v.stb_cycles) ? 32'(hot) : 32'h0);
        if (n <= v.stb_cycles) begin
          check_output("we_o", d, 32'(we_o[d]), 32'(v.we));
          check_output("addr_o", d, 32'(addr_o[d]), 32'(v.rsel));
          check_output("dat_w_o", d, dat_w_o[d], v.wdata);
        end
        check_output("ack", d, 32'(ack_o[d]), 32'(n == v.lat && !e));
        check_output("err", d, 32'(err_o[d]), 32'(n == v.lat && e));
        if (n == v.lat) check_output("dat_o", d, dat_o[d], v.dat);
      end
      if (n == v.lat) begin
        cyc = 1'b0;
        stb = 1'b0;
      end
      noise = 8'($urandom) & ~hot;
      if (stb_o[0][v.slot]) begin
        if (seen == v.waits) noise[v.slot] = 1'b1;
        seen++;
      end
      ack_i = noise;
    end
    ack_i = '0;
    for (int d = 0; d < 2; d++) begin
      e = (d == 0) ? v.err_a : v.err_b;
      if (v.clr) mv[d] = 1'b0;
      if (e) begin
        mv[d] = 1'b1;
        ms[d] = v.slot;
        mt[d] = v.tmo;
      end
    end
    check_latch("latch");
  endtask

  function automatic vec_t gen_vec();
    vec_t v;
    v.slot  = 3'($urandom_range(0, NS - 1));
    v.rsel  = 5'($urandom);
    v.we    = 1'($urandom);
    v.wdata = $urandom;
    v.rdata = $urandom;
    v.waits = int'($urandom_range(0, TMO + 1));
    v.clr   = ($urandom_range(0, 3) == 0);
    if (!EN[v.slot]) begin
      v.lat = 1; v.stb_cycles = 0; v.err_a = 1'b0; v.err_b = 1'b1; v.tmo = 1'b0; v.dat = '0;
    end else if (v.waits < TMO) begin
      v.lat = v.waits + 2; v.stb_cycles = v.waits + 1; v.err_a = 1'b0; v.err_b = 1'b0;
      v.tmo = 1'b0; v.dat = v.we ? 32'h0 : v.rdata;
    end else begin
      v.lat = TMO + 1; v.stb_cycles = TMO; v.err_a = 1'b1; v.err_b = 1'b1; v.tmo = 1'b1; v.dat = '0;
    end
    return v;
  endfunction

  vec_t tbl [8];

  initial begin
    tbl[0] = '{3'd2, 5'd1,  1'b1, 32'hA5,       32'hDEADBEEF, 0,   1'b0, 2, 1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{3'd1, 5'd3,  1'b0, 32'h0,        32'h12345678, 3,   1'b0, 5, 4, 1'b0, 1'b0, 1'b0, 32'h12345678};
    tbl[2] = '{3'd5, 5'd0,  1'b0, 32'h0,        32'hCAFEF00D, 0,   1'b0, 1, 0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[3] = '{3'd0, 5'd4,  1'b0, 32'h0,        32'h11111111, 100, 1'b0, 9, 8, 1'b1, 1'b1, 1'b1, 32'h0};
    tbl[4] = '{3'd6, 5'd2,  1'b1, 32'h55,       32'h0,        0,   1'b1, 1, 0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[5] = '{3'd2, 5'd31, 1'b0, 32'h0,        32'hA5A5A5A5, 7,   1'b0, 9, 8, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5};
    tbl[6] = '{3'd0, 5'd0,  1'b0, 32'h0,        32'h77,       8,   1'b0, 9, 8, 1'b1, 1'b1, 1'b1, 32'h0};
    tbl[7] = '{3'd1, 5'd2,  1'b1, 32'hFFFFFFFF, 32'hBEEF,     2,   1'b0, 4, 3, 1'b0, 1'b0, 1'b0, 32'h0};
    for (int d = 0; d < 2; d++) begin
      mv[d] = 1'b0; ms[d] = '0; mt[d] = 1'b0;
    end

    tick();
    tick();
    check_zero("reset");
    RST_I = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) apply_stimulus(tbl[i]);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    for (int d = 0; d < 2; d++) mv[d] = 1'b0;
    check_latch("err_clr");

    // Abort on the second REQ cycle, then a late ACK from the abandoned slot.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = {3'd0, 5'd9}; ack_i = '0;
    tick();
    for (int d = 0; d < 2; d++) check_output("abort_stb1", d, 32'(stb_o[d]), 32'h1);
    tick();
    for (int d = 0; d < 2; d++) check_output("abort_stb2", d, 32'(stb_o[d]), 32'h1);
    cyc = 1'b0; stb = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      check_output("abort_stb3", d, 32'(stb_o[d]), 32'h0);
      check_output("abort_ack", d, 32'(ack_o[d]), 32'h0);
      check_output("abort_err", d, 32'(err_o[d]), 32'h0);
    end
    ack_i = 8'h01;
    tick();
    for (int d = 0; d < 2; d++) begin
      check_output("late_ack", d, 32'(ack_o[d]), 32'h0);
      check_output("late_err", d, 32'(err_o[d]), 32'h0);
      check_output("late_stb", d, 32'(stb_o[d]), 32'h0);
    end
    ack_i = '0;
    check_latch("abort");

    for (int i = 0; i < 200; i++) begin
      apply_stimulus(gen_vec());
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset in the middle of a REQ phase must clear everything without waiting for a clock edge.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = {3'd1, 5'd7}; wdat = 32'h3C3C3C3C; ack_i = '0;
    tick();
    for (int d = 0; d < 2; d++) check_output("pre_rst_stb", d, 32'(stb_o[d]), 32'h2);
    #2 RST_I = 1'b1;
    #1 check_zero("async_rst");
    for (int d = 0; d < 2; d++) begin
      mv[d] = 1'b0; ms[d] = '0; mt[d] = 1'b0;
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge CLK_I);
    RST_I = 1'b0;
    tick();

    for (int i = 0; i < 20; i++) apply_stimulus(gen_vec());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mmio_slot_router.md
Name: mmio_slot_router

Overview:
- Parametrised WISHBONE MMIO slot router. It replaces the fixed-slot controller with a registered, timeout-protected decoder for N_SLOTS cores.
- Sits between the CPU-side WISHBONE bus and the per-slot I/O cores (timer, UART, GPO, ...).
- Slots that are disabled in a mask, or that never acknowledge, get a deterministic response instead of hanging the bus.
- Latches diagnostic information about the last failing access.

Parameters:
- N_SLOTS, 64, number of slots; power of two, at least 2. SLOT_AW = clog2(N_SLOTS).
- REG_AW, 5, register address width inside a slot.
- DW, 32, data width.
- SLOT_EN, all ones, N_SLOTS-bit mask; bit s=1 means slot s has a core attached.
- UNUSED_ERR, 0, 0 = disabled slot answers ACK_O with data 0; 1 = disabled slot answers ERR_O.
- TIMEOUT, 255, maximum number of REQ cycles without ACK_I before an error; range 1..65535.

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  reset, asynchronous, active-high
- ADDR_I  in  SLOT_AW+REG_AW  word address; slot = ADDR_I[SLOT_AW+REG_AW-1:REG_AW], reg = ADDR_I[REG_AW-1:0]
- DAT_I  in  DW  write data
- DAT_O  out  DW  read data
- CYC_I  in  1  bus cycle
- STB_I  in  1  strobe
- WE_I  in  1  write enable
- ACK_O  out  1  normal termination
- ERR_O  out  1  error termination
- CYC_O  out  N_SLOTS  per-slot cycle
- STB_O  out  N_SLOTS  per-slot strobe
- WE_O  out  1  broadcast write enable
- ADDR_O  out  REG_AW  broadcast register address
- DAT_W_O  out  DW  broadcast write data
- DAT_R_I  in  N_SLOTS*DW  slot read data, flattened; slot s occupies [s*DW +: DW]
- ACK_I  in  N_SLOTS  per-slot acknowledge
- err_valid  out  1  sticky flag: an error has been latched
- err_slot  out  SLOT_AW  slot of the most recent error
- err_timeout  out  1  1 = most recent error was a timeout, 0 = disabled-slot error
- err_clr  in  1  clears err_valid

Behaviour:
- Reset: state IDLE, counter 0, latches 0. All outputs are 0: DAT_O, ACK_O, ERR_O, CYC_O, STB_O, WE_O, ADDR_O, DAT_W_O, err_*.
- FSM states are IDLE, REQ, RESP.
- IDLE:
  - On CYC_I&STB_I, register slot, reg, WE_I and DAT_I.
  - If SLOT_EN[slot]=1, go to REQ.
  - Otherwise go to RESP. DAT_O=0. If UNUSED_ERR=0, set ACK; if UNUSED_ERR=1, set ERR and latch the error with err_timeout=0.
- REQ:
  - CYC_O[slot]=STB_O[slot]=1, all other bits 0. WE_O, ADDR_O and DAT_W_O hold the latched values. Counter increments each cycle.
  - If ACK_I[slot]=1, capture the slot's DAT_R_I segment into DAT_O (DAT_O=0 on writes) and go to RESP with ACK.
  - Else, when the counter reaches TIMEOUT-1, go to RESP with ERR, DAT_O=0, and latch the error with err_timeout=1.
  - ACK_I from any other slot is ignored.
- RESP:
  - Exactly one of ACK_O or ERR_O is high for exactly 1 cycle. DAT_O is valid in that cycle.
  - Downstream CYC_O/STB_O are 0. Counter resets. Next state is IDLE.
- Latency:
  - Enabled slot with combinational ACK: request cycle t, STB_O at t+1, ACK_O at t+2.
  - Each extra slave wait cycle adds 1.
  - Disabled slot: ACK_O/ERR_O at t+1.
  - Timeout: ERR_O at t+1+TIMEOUT.
- Back-to-back: if STB_I is still high in the IDLE cycle after RESP, it is a new request. The master must drop STB_I after ACK_O/ERR_O unless it issues a new access.
- Abort: CYC_I=0 while in REQ returns to IDLE next cycle. Downstream is deasserted, there is no ACK_O/ERR_O and no error is latched.
- Outputs DAT_O, ACK_O and ERR_O are registered.
- Error latch:
  - On an error, err_valid=1 and err_slot/err_timeout are overwritten.
  - err_clr=1 clears err_valid the next cycle.
  - If err_clr and a new error occur in the same cycle, the new error wins (err_valid stays 1).
- Asserting RST_I mid-transaction immediately forces all outputs to 0 and the state to IDLE.

Test Plan:
- Write slot 2 reg 1 with DAT_I=0x000000A5, slave ACKs in the first REQ cycle -> STB_O=0x4 for 1 cycle, ADDR_O=1, DAT_W_O=0xA5, WE_O=1; ACK_O 2 cycles after the request; err_valid=0.
- Read slot 1 reg 3, slave returns 0x12345678 after 3 wait cycles -> STB_O[1] high for 4 cycles; ACK_O with DAT_O=0x12345678 at t+5.
- SLOT_EN=0x7, access slot 5, UNUSED_ERR=0 -> ACK_O at t+1, DAT_O=0, no STB_O. Same with UNUSED_ERR=1 -> ERR_O at t+1, err_valid=1, err_slot=5, err_timeout=0.
- TIMEOUT=8, slot 0 never ACKs -> STB_O[0] high for 8 cycles, ERR_O at t+9, err_slot=0, err_timeout=1. Then pulse err_clr -> err_valid=0.
- Drop CYC_I on the 2nd REQ cycle -> STB_O=0 next cycle, no ACK_O/ERR_O. A late ACK_I[0] is ignored. Assert RST_I during REQ -> all outputs 0 asynchronously.
